// File: rtl/store_buffer.sv
// store_buffer: circular FIFO of pending core stores. Entries drain to data
// memory in order, and loads can take their data from pending stores.
//
// Ports:
//   clk, reset                        sole clock; synchronous active-high reset
//   st_valid/st_addr/st_data/st_byte  store request from the core; st_ready = !full
//   ld_valid/ld_addr/ld_byte          load lookup from the core
//   ld_hit/ld_data/ld_stall           combinational forwarding result
//   mem_we/mem_addr/mem_wdata/mem_byte  head entry drain request; mem_ack accepts it
//   count/full/empty                  occupancy status
module store_buffer #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [DATA_W-1:0]          st_data,
    input  logic                       st_byte,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [ADDR_W-1:0]          ld_addr,
    input  logic                       ld_byte,
    output logic                       ld_hit,
    output logic [DATA_W-1:0]          ld_data,
    output logic                       ld_stall,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic                       mem_byte,
    input  logic                       mem_ack,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] entryAddr [DEPTH];
    logic [DATA_W-1:0] entryData [DEPTH];
    logic              entryByte [DEPTH];

    logic [PTR_W-1:0]  headPtr;
    logic [PTR_W-1:0]  tailPtr;
    logic [CNT_W-1:0]  entryCount;

    logic              doEnq;
    logic              doDeq;

    logic              matchFound;
    logic [PTR_W-1:0]  matchIdx;
    logic [PTR_W-1:0]  scanIdx;
    logic [DATA_W-1:0] laneWord;

    // Status and handshakes
    assign full     = (entryCount == CNT_W'(DEPTH));
    assign empty    = (entryCount == '0);
    assign count    = entryCount;
    assign st_ready = !full;
    assign mem_we   = !empty;
    assign doEnq    = st_valid && !full;
    assign doDeq    = mem_we && mem_ack;

    assign mem_addr  = entryAddr[headPtr];
    assign mem_wdata = entryData[headPtr];
    assign mem_byte  = entryByte[headPtr];

    // Pointers and occupancy; power-of-two DEPTH lets pointers wrap by truncation
    always_ff @(posedge clk) begin
        if (reset) begin
            headPtr    <= '0;
            tailPtr    <= '0;
            entryCount <= '0;
        end else begin
            if (doEnq) tailPtr <= PTR_W'(tailPtr + 1'b1);
            if (doDeq) headPtr <= PTR_W'(headPtr + 1'b1);
            if (doEnq && !doDeq)      entryCount <= CNT_W'(entryCount + 1'b1);
            else if (doDeq && !doEnq) entryCount <= CNT_W'(entryCount - 1'b1);
        end
    end

    // Entry storage needs no reset; validity comes from head/count
    always_ff @(posedge clk) begin
        if (!reset && doEnq) begin
            entryAddr[tailPtr] <= st_addr;
            entryData[tailPtr] <= st_data;
            entryByte[tailPtr] <= st_byte;
        end
    end

    // Scan oldest to youngest so the last word-aligned match is the youngest
    always_comb begin
        matchFound = 1'b0;
        matchIdx   = '0;
        scanIdx    = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            scanIdx = PTR_W'(headPtr + PTR_W'(k));
            if ((CNT_W'(k) < entryCount) &&
                (entryAddr[scanIdx][ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
                matchFound = 1'b1;
                matchIdx   = scanIdx;
            end
        end
    end

    assign laneWord = entryData[matchIdx] >> {ld_addr[1:0], 3'b000};

    // Forwarding decision: word stores forward any load, byte stores only an exact byte load
    always_comb begin
        ld_hit   = 1'b0;
        ld_stall = 1'b0;
        ld_data  = '0;
        if (ld_valid && matchFound) begin
            if (!entryByte[matchIdx]) begin
                ld_hit  = 1'b1;
                ld_data = ld_byte ? DATA_W'(laneWord[7:0]) : entryData[matchIdx];
            end else if (ld_byte && (entryAddr[matchIdx] == ld_addr)) begin
                ld_hit  = 1'b1;
                ld_data = DATA_W'(entryData[matchIdx][7:0]);
            end else begin
                ld_stall = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_byte;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_byte;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        ld_stall;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_byte;
    logic        mem_ack;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        isByte;
    } entry_t;

    entry_t q[$];

    store_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_byte(st_byte),
        .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_byte(ld_byte),
        .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byte(mem_byte),
        .mem_ack(mem_ack), .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Reference forwarding: walk the pending stores from youngest to oldest
    function automatic void model_load(input logic [31:0] a, input logic lb,
                                       output logic hit, output logic stall,
                                       output logic [31:0] d);
        hit = 1'b0; stall = 1'b0; d = 32'h0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].addr[31:2] == a[31:2]) begin
                if (!q[i].isByte) begin
                    hit = 1'b1;
                    if (lb) d = {24'h0, q[i].data[8*a[1:0] +: 8]};
                    else    d = q[i].data;
                end else if (lb && q[i].addr == a) begin
                    hit = 1'b1;
                    d   = {24'h0, q[i].data[7:0]};
                end else begin
                    stall = 1'b1;
                end
                return;
            end
        end
    endfunction

    // One clock of store/ack stimulus; keeps the reference queue in step
    task automatic drive_cycle(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                               input logic sb, input logic ack);
        bit accept, drain;
        st_valid = sv; st_addr = sa; st_data = sd; st_byte = sb; mem_ack = ack;
        #1;
        accept = sv && (q.size() < DEPTH);
        drain  = ack && (q.size() > 0);
        @(posedge clk);
        if (drain) void'(q.pop_front());
        if (accept) q.push_back('{addr: sa, data: sd, isByte: sb});
        #1;
        st_valid = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; st_valid = 1'b1; st_addr = 32'h40; st_data = 32'h1234; st_byte = 1'b0;
        mem_ack = 1'b1; ld_valid = 1'b0; ld_addr = 32'h0; ld_byte = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        st_valid = 1'b0; mem_ack = 1'b0; reset = 1'b0;
        q.delete();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready: got %b expected 1", st_ready); end
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 32'h400 + 32'(4 * i), 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
            checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count: got %0d expected %0d", count, i + 1); end
        end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b expected 1", full); end
        checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL full_st_ready: got %b expected 0", st_ready); end
        drive_cycle(1'b1, 32'h500, 32'hDEAD_BEEF, 1'b0, 1'b0);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL dropped_count: got %0d expected 4", count); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem_addr !== 32'h400 + 32'(4 * i)) begin errors++; $display("FAIL drain_addr: got %h expected %h", mem_addr, 32'h400 + 32'(4 * i)); end
            drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drained_empty: got %b expected 1", empty); end
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL ack_when_empty: got %0d expected 0", count); end
    endtask

    task automatic test_forward_lane();
        apply_reset();
        drive_cycle(1'b1, 32'h100, 32'hAABB_CCDD, 1'b0, 1'b0);
        ld_valid = 1'b1; ld_addr = 32'h102; ld_byte = 1'b1; #1;
        checks++; if (ld_hit !== 1'b1) begin errors++; $display("FAIL lane_hit: got %b expected 1", ld_hit); end
        checks++; if (ld_data !== 32'h0000_00BB) begin errors++; $display("FAIL lane_data: got %h expected 000000bb", ld_data); end
        ld_addr = 32'h100; ld_byte = 1'b0; #1;
        checks++; if (ld_data !== 32'hAABB_CCDD) begin errors++; $display("FAIL word_data: got %h expected aabbccdd", ld_data); end
        // A store entering this cycle is not yet a source
        ld_addr = 32'h600; st_valid = 1'b1; st_addr = 32'h600; st_data = 32'h7777_7777; st_byte = 1'b0; #1;
        checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL same_cycle_hit: got %b expected 0", ld_hit); end
        st_valid = 1'b0; ld_valid = 1'b0; #1;
        checks++; if (ld_data !== 32'h0) begin errors++; $display("FAIL idle_data: got %h expected 0", ld_data); end
    endtask

    task automatic test_youngest();
        apply_reset();
        drive_cycle(1'b1, 32'h200, 32'h1111_1111, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h200, 32'h2222_2222, 1'b0, 1'b0);
        ld_valid = 1'b1; ld_addr = 32'h200; ld_byte = 1'b0; #1;
        checks++; if (ld_data !== 32'h2222_2222) begin errors++; $display("FAIL youngest_data: got %h expected 22222222", ld_data); end
        ld_valid = 1'b0;
    endtask

    task automatic test_byte_stall();
        apply_reset();
        drive_cycle(1'b1, 32'h301, 32'h0000_005A, 1'b1, 1'b0);
        drive_cycle(1'b1, 32'h900, 32'h1357_9BDF, 1'b0, 1'b0);
        ld_valid = 1'b1; ld_addr = 32'h300; ld_byte = 1'b0; #1;
        checks++; if (ld_stall !== 1'b1 || ld_hit !== 1'b0) begin errors++; $display("FAIL byte_overlap: got stall=%b hit=%b expected stall=1 hit=0", ld_stall, ld_hit); end
        ld_addr = 32'h301; ld_byte = 1'b1; #1;
        checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h5A) begin errors++; $display("FAIL byte_exact: got hit=%b data=%h expected hit=1 data=5a", ld_hit, ld_data); end
        ld_addr = 32'h300; ld_byte = 1'b0; mem_ack = 1'b1; #1;
        // The head being acknowledged still forwards this cycle
        checks++; if (ld_stall !== 1'b1) begin errors++; $display("FAIL dequeue_cycle_stall: got %b expected 1", ld_stall); end
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        #1;
        checks++; if (ld_stall !== 1'b0 || ld_hit !== 1'b0) begin errors++; $display("FAIL after_drain: got stall=%b hit=%b expected 0 0", ld_stall, ld_hit); end
        ld_valid = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] a;
        apply_reset();
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 32'h800 + 32'(4 * i), 32'(i), 1'b0, 1'b0);
        drive_cycle(1'b1, 32'hF00, 32'hFFFF_FFFF, 1'b0, 1'b1);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_push_ack_count: got %0d expected 3", count); end
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                drive_cycle(1'b1, 32'hA00 + 32'(4 * i), 32'hB0 + 32'(i), 1'b0, 1'b0);
            end else begin
                a = q[0].addr;
                checks++; if (mem_addr !== a) begin errors++; $display("FAIL wrap_order: got %h expected %h", mem_addr, a); end
                drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
            end
        end
        while (q.size() > 0) begin
            a = q[0].addr;
            checks++; if (mem_addr !== a) begin errors++; $display("FAIL wrap_drain_order: got %h expected %h", mem_addr, a); end
            drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 32'h700 + 32'(4 * i), 32'(i), 1'b0, 1'b0);
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL pending_mem_we: got %b expected 1", mem_we); end
        reset = 1'b1; st_valid = 1'b1; mem_ack = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; st_valid = 1'b0; mem_ack = 1'b0;
        q.delete();
        checks++; if (count !== 3'd0 || mem_we !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL mid_reset: got count=%0d mem_we=%b empty=%b expected 0 0 1", count, mem_we, empty); end
    endtask

    task automatic test_random();
        logic eh, es;
        logic [31:0] ed;
        logic sv, sb, ack;
        logic [31:0] sa, sd;
        int bad;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            sv  = ($urandom_range(0, 99) < 55);
            sa  = 32'h1000 + 32'($urandom_range(0, 15));
            sd  = $urandom;
            sb  = $urandom_range(0, 1) == 1;
            ack = ($urandom_range(0, 99) < 45);
            ld_valid = ($urandom_range(0, 9) != 0);
            ld_addr  = 32'h1000 + 32'($urandom_range(0, 15));
            ld_byte  = $urandom_range(0, 1) == 1;
            st_valid = sv; st_addr = sa; st_data = sd; st_byte = sb; mem_ack = ack;
            #1;
            if (ld_valid) model_load(ld_addr, ld_byte, eh, es, ed);
            else begin eh = 1'b0; es = 1'b0; ed = 32'h0; end
            checks++; if (ld_hit !== eh || ld_stall !== es || ld_data !== ed) begin
                errors++; $display("FAIL rand_load: got hit=%b stall=%b data=%h expected hit=%b stall=%b data=%h", ld_hit, ld_stall, ld_data, eh, es, ed);
            end
            checks++; if (count !== 3'(q.size()) || full !== (q.size() == DEPTH) || st_ready !== (q.size() != DEPTH)) begin
                errors++; $display("FAIL rand_status: got count=%0d full=%b st_ready=%b expected count=%0d", count, full, st_ready, q.size());
            end
            if (q.size() > 0) begin
                bad = 0;
                if (mem_we !== 1'b1 || mem_addr !== q[0].addr || mem_byte !== q[0].isByte) bad = 1;
                if (mem_wdata[7:0] !== q[0].data[7:0]) bad = 1;
                if (!q[0].isByte && mem_wdata !== q[0].data) bad = 1;
                checks++; if (bad != 0) begin errors++; $display("FAIL rand_head: got we=%b addr=%h data=%h byte=%b expected addr=%h data=%h byte=%b", mem_we, mem_addr, mem_wdata, mem_byte, q[0].addr, q[0].data, q[0].isByte); end
            end else begin
                checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rand_idle_we: got %b expected 0", mem_we); end
            end
            drive_cycle(sv, sa, sd, sb, ack);
        end
        ld_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full();
        test_forward_lane();
        test_youngest();
        test_byte_stall();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter ADDR_W, default 32, byte address width.
REQ-002 Parameter DATA_W, default 32, store data width; fixed at 32 for byte-lane extraction.
REQ-003 Parameter DEPTH, default 4, entry count; power of two, at least 2.
REQ-004 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 Port reset, input, 1, synchronous, active-high.
REQ-006 st_valid, input, 1, core store request (MemWrite).
REQ-007 st_addr, input, ADDR_W, store byte address (ALUOut).
REQ-008 st_data, input, DATA_W, store data (WriteData); for byte stores only bits [7:0] are used.
REQ-009 st_byte, input, 1, 1 selects byte store, 0 selects word store.
REQ-010 st_ready, output, 1, buffer can accept a store this cycle.
REQ-011 ld_valid, input, 1, core load lookup.
REQ-012 ld_addr, input, ADDR_W, load byte address.
REQ-013 ld_byte, input, 1, byte load (LoadW/ByteW).
REQ-014 ld_hit, output, 1, forwarded data valid.
REQ-015 ld_data, output, DATA_W, forwarded data.
REQ-016 ld_stall, output, 1, load must wait because of unforwardable overlap.
REQ-017 mem_we, output, 1, drain request to data memory.
REQ-018 mem_addr, mem_wdata, mem_byte, outputs, ADDR_W / DATA_W / 1, head entry fields.
REQ-019 mem_ack, input, 1, memory accepted the head write (dhit-style).
REQ-020 count, output, log2(DEPTH)+1, occupancy; full and empty outputs, 1 bit each.

Function
REQ-021 Circular FIFO; each entry holds addr, data, byte flag; head and tail pointers wrap modulo DEPTH.
REQ-022 st_ready = !full, combinational; no full-with-drain bypass.
REQ-023 Enqueue occurs when st_valid && st_ready; entry is written at tail and tail advances at the next edge.
REQ-024 st_valid while full is ignored; the core is responsible for holding the request.
REQ-025 mem_we = !empty; mem_addr, mem_wdata and mem_byte are taken from head and are stable until acknowledged.
REQ-026 Dequeue occurs when mem_we && mem_ack; mem_ack while empty is ignored.
REQ-027 Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
REQ-028 count increments or decrements by one per edge; full = (count == DEPTH), empty = (count == 0).
REQ-029 Forwarding is combinational over valid entries only; a store enqueued in the same cycle is not visible.
REQ-030 Match rule: entry addr[ADDR_W-1:2] equals ld_addr[ADDR_W-1:2]; the youngest matching entry wins.
REQ-031 Youngest match is a word store: ld_hit = 1; a word load returns the full data; a byte load returns lane ld_addr[1:0], zero-extended.
REQ-032 Youngest match is a byte store, and the load is a byte load to the exact same address: ld_hit = 1 with data[7:0] zero-extended.
REQ-033 Youngest match is any other byte store: ld_hit = 0 and ld_stall = 1.
REQ-034 No match or ld_valid = 0: ld_hit = 0, ld_stall = 0, ld_data = 0.
REQ-035 An entry dequeued in a given cycle is still a forwarding source in that cycle.

Reset
REQ-036 When reset is high at an edge: head, tail and count are cleared to 0; empty = 1; full = 0; mem_we = 0.
REQ-037 Reset in mid-operation discards all entries, including an unacknowledged head; mem_we is low from the next cycle.
REQ-038 While reset is high, st_valid and mem_ack have no effect; entry storage need not be cleared.

Verification
REQ-039 DEPTH = 4: issue 4 word stores with no ack -> full = 1, st_ready = 0; a 5th store is dropped; count = 4.
REQ-040 Store word 0xAABBCCDD to 0x100, then byte load 0x102 -> ld_hit = 1, ld_data = 0x000000BB.
REQ-041 Word store 0x11111111 to 0x200, then word store 0x22222222 to 0x200, then load 0x200 -> ld_data = 0x22222222 (youngest match wins).
REQ-042 Byte store to 0x301, then word load 0x300 -> ld_stall = 1; ack both entries -> ld_stall = 0, ld_hit = 0.
REQ-043 Full buffer with st_valid and mem_ack in the same cycle -> store not accepted; count = 3 next cycle; then 8 alternating push/ack cycles confirm pointer wrap and FIFO order of mem_addr.
REQ-044 Reset asserted with 3 entries pending and mem_we high -> next cycle count = 0, mem_we = 0, empty = 1.
